// File: rtl/fir_out_requant.sv
// fir_out_requant
//   Output requantiser for the FIR decimator. Each full-precision sample is
//   rounded (round-half-toward-+inf) after an arithmetic right shift by SHIFT,
//   range-limited to OUT_W bits, tagged with a frame-end marker and buffered
//   in a FIFO that drives an AXI-Stream-style master port.
//
//   Build option: define REQUANT_SAT_EN to clamp out-of-range results to the
//   OUT_W extremes; leave it undefined to wrap (keep the low OUT_W bits).
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   in_data   signed IN_W sample from the FIR, qualified by in_vld
//   in_vld    one-cycle sample qualifier (no backpressure)
//   m_tdata   requantised sample at the FIFO head (0 while empty)
//   m_tvalid  FIFO not empty
//   m_tready  downstream accept
//   m_tlast   head sample is the last of a FRAME_LEN frame
//   clip      one-cycle pulse for an out-of-range stage-2 result
//   ovf       sticky: a sample was dropped because the FIFO was full
module fir_out_requant #(
  parameter int IN_W       = 24,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_vld,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             clip,
  output logic             ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  // OUT_W range expressed in the IN_W+1 bit stage-1 domain
  localparam logic signed [IN_W:0] R_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] R_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] Q_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Q_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Add half an LSB of the shifted result, then shift; one guard bit keeps
  // the add from overflowing. half is zero when SHIFT is zero.
  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] half;
    ext  = {x[IN_W-1], x};
    half = ((IN_W+1)'(1) << SHIFT) >> 1;
    return (ext + half) >>> SHIFT;
  endfunction

  function automatic logic out_of_range(input logic signed [IN_W:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] requant(input logic signed [IN_W:0] r);
`ifdef REQUANT_SAT_EN
    if (r > R_MAX)      return Q_MAX;
    else if (r < R_MIN) return Q_MIN;
    else                return r[OUT_W-1:0];
`else
    return r[OUT_W-1:0];
`endif
  endfunction

  logic signed [IN_W-1:0]  in_data_s;
  logic signed [IN_W:0]    r_p1;
  logic                    vld_p1;
  logic signed [OUT_W-1:0] q_p2;
  logic                    vld_p2;

  logic [FW-1:0]  frm_cnt;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [OUT_W:0] mem [FIFO_DEPTH];
  logic [OUT_W:0] head;
  logic           full;
  logic           rd_en;
  logic           wr_en;
  logic           last_p2;

  assign in_data_s = in_data;

  // ---- stage 1: round and shift ----
  // ---- stage 2: range check and requantise ----
  always_ff @(posedge clk) begin
    if (in_vld) r_p1 <= round_shift(in_data_s);
    if (vld_p1) q_p2 <= requant(r_p1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      clip   <= 1'b0;
    end else begin
      vld_p1 <= in_vld;
      vld_p2 <= vld_p1;
      clip   <= vld_p1 && out_of_range(r_p1);
    end
  end

  // ---- stage 3: frame tagging and FIFO write ----
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_en   = m_tvalid & m_tready;
  // A read in the same cycle frees the slot a full FIFO would otherwise refuse
  assign wr_en   = vld_p2 & (~full | rd_en);
  assign last_p2 = (frm_cnt == FW'(FRAME_LEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      // Dropped samples still advance the frame so tlast stays aligned
      if (vld_p2) frm_cnt <= last_p2 ? '0 : frm_cnt + 1'b1;
      if (vld_p2 && full && !rd_en) ovf <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {last_p2, q_p2};
  end

  // Head comes straight from storage, so it is stable until the pointer moves
  assign head     = mem[rd_ptr];
  assign m_tvalid = (count != '0);
  assign m_tdata  = m_tvalid ? head[OUT_W-1:0] : '0;
  assign m_tlast  = m_tvalid & head[OUT_W];

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant (FRAME_LEN=4, other parameters at
// default). Directed scenarios use hand-derived constants; a randomized run
// is checked cycle by cycle against a behavioural model of the stream.
module tb_fir_out_requant;

  localparam int IN_W       = 24;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FRAME_LEN  = 4;

  localparam longint OMAX = (longint'(1) << (OUT_W-1)) - 1;
  localparam longint OMIN = -(longint'(1) << (OUT_W-1));

`ifdef REQUANT_SAT_EN
  localparam logic [15:0] EXP_POS_FULL = 16'h7FFF;
`else
  localparam logic [15:0] EXP_POS_FULL = 16'h8000;
`endif

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_vld;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic             clip;
  logic             ovf;

  int n_chk;
  int n_pass;

  fir_out_requant #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
    .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .clip(clip), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic longint ref_round(input logic [IN_W-1:0] x);
    longint v, d, q;
    d = longint'(1) << SHIFT;
    v = longint'($signed(x)) + d / 2;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;   // floor division
    return q;
  endfunction

  function automatic logic ref_clip(input logic [IN_W-1:0] x);
    longint q;
    q = ref_round(x);
    return (q > OMAX) || (q < OMIN);
  endfunction

  function automatic logic [OUT_W-1:0] ref_data(input logic [IN_W-1:0] x);
    longint q;
    q = ref_round(x);
`ifdef REQUANT_SAT_EN
    if (q > OMAX) q = OMAX;
    if (q < OMIN) q = OMIN;
`endif
    return q[OUT_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return 24'h7FFF80 + 24'($urandom_range(0, 127));
      1:       return 24'h800000 + 24'($urandom_range(0, 255));
      2:       return {16'($urandom), 8'h80};
      default: return 24'($urandom);
    endcase
  endfunction

  // ---------------- behavioural stream model ----------------
  // Samples reach the buffer two edges after capture; the buffer holds at
  // most FIFO_DEPTH entries and a pop in the same cycle makes room.
  logic [OUT_W:0]  exp_q[$];
  logic            mv1, mv2;
  logic [IN_W-1:0] md1, md2;
  int              m_frm;
  logic            exp_ovf;
  logic            exp_clip;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      mv1      <= 1'b0;
      mv2      <= 1'b0;
      m_frm    <= 0;
      exp_ovf  <= 1'b0;
      exp_clip <= 1'b0;
    end else begin
      if (m_tready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (mv2) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({(m_frm == FRAME_LEN-1), ref_data(md2)});
        else exp_ovf <= 1'b1;
        m_frm <= (m_frm + 1) % FRAME_LEN;
      end
      exp_clip <= mv1 && ref_clip(md1);
      mv1 <= in_vld;
      md1 <= in_data;
      mv2 <= mv1;
      md2 <= md1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; m_tready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b1; in_data = 24'h123456; m_tready = 1'b0;
    tick(); in_vld = 1'b0; tick(); tick();
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_tvalid); else n_pass++;
    n_chk++; if (m_tdata !== 16'h0) $display("FAIL reset_tdata: got %h want 0000", m_tdata); else n_pass++;
    n_chk++; if (m_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_tlast); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    n_chk++; if (clip !== 1'b0) $display("FAIL reset_clip: got %b want 0", clip); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    m_tready = 1'b1;
    in_vld = 1'b1; in_data = 24'h000180;
    tick();
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL basic_lat1: tvalid got %b want 0", m_tvalid); else n_pass++;
    in_data = 24'hFFFE80;
    tick();
    in_vld = 1'b0;
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL basic_lat2: tvalid got %b want 0", m_tvalid); else n_pass++;
    tick();
    n_chk++; if (m_tvalid !== 1'b1) $display("FAIL basic_lat3: tvalid got %b want 1", m_tvalid); else n_pass++;
    n_chk++; if (m_tdata !== 16'h0002) $display("FAIL basic_d0: got %h want 0002", m_tdata); else n_pass++;
    tick();
    n_chk++; if (m_tdata !== 16'hFFFF) $display("FAIL basic_d1: got %h want ffff", m_tdata); else n_pass++;
    n_chk++; if (m_tlast !== 1'b0) $display("FAIL basic_tlast: got %b want 0", m_tlast); else n_pass++;
    tick();
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL basic_empty: tvalid got %b want 0", m_tvalid); else n_pass++;
  endtask

  task automatic test_extremes();
    logic [IN_W-1:0] stim [2];
    logic [15:0]     want [2];
    int              want_clips [2];
    stim[0] = 24'h7FFFFF; want[0] = EXP_POS_FULL; want_clips[0] = 1;
    stim[1] = 24'h800000; want[1] = 16'h8000;     want_clips[1] = 0;
    for (int s = 0; s < 2; s++) begin
      int          clips, clip_at;
      logic [15:0] got;
      do_reset();
      m_tready = 1'b1;
      clips = 0; clip_at = -1; got = 16'hDEAD;
      in_vld = 1'b1; in_data = stim[s];
      tick();
      in_vld = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (clip === 1'b1) begin clips++; if (clip_at < 0) clip_at = i; end
        if (m_tvalid === 1'b1) got = m_tdata;
      end
      n_chk++; if (got !== want[s]) $display("FAIL extreme_data[%0d]: got %h want %h", s, got, want[s]); else n_pass++;
      n_chk++; if (clips != want_clips[s]) $display("FAIL extreme_clips[%0d]: got %0d want %0d", s, clips, want_clips[s]); else n_pass++;
      if (s == 0) begin
        n_chk++; if (clip_at != 0) $display("FAIL extreme_clip_cycle: got %0d want 0", clip_at); else n_pass++;
      end
    end
  endtask

  task automatic test_frame();
    logic [IN_W-1:0]  arr [10];
    logic [OUT_W-1:0] got_d [16];
    logic             got_l [16];
    int               k;
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) arr[i] = rand_sample();
    k = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_tvalid === 1'b1 && k < 16) begin got_d[k] = m_tdata; got_l[k] = m_tlast; k++; end
      in_vld  = (c < 10);
      in_data = (c < 10) ? arr[c] : '0;
      tick();
    end
    n_chk++; if (k != 10) $display("FAIL frame_count: got %0d want 10", k); else n_pass++;
    for (int j = 0; j < 10 && j < k; j++) begin
      n_chk++;
      if (got_l[j] !== (j == 3 || j == 7)) $display("FAIL frame_tlast[%0d]: got %b want %b", j, got_l[j], (j == 3 || j == 7));
      else n_pass++;
      n_chk++;
      if (got_d[j] !== ref_data(arr[j])) $display("FAIL frame_data[%0d]: got %h want %h", j, got_d[j], ref_data(arr[j]));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [IN_W-1:0]  arr [20];
    logic [OUT_W-1:0] got_d [32];
    logic             got_l [32];
    int               k;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      arr[i] = rand_sample();
      in_vld = 1'b1; in_data = arr[i];
      tick();
    end
    in_vld = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (m_tvalid !== 1'b1) $display("FAIL ovf_tvalid: got %b want 1", m_tvalid); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
    m_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (m_tvalid === 1'b1 && k < 32) begin got_d[k] = m_tdata; got_l[k] = m_tlast; k++; end
      tick();
    end
    n_chk++; if (k != 16) $display("FAIL ovf_drain_count: got %0d want 16", k); else n_pass++;
    for (int j = 0; j < 16 && j < k; j++) begin
      n_chk++;
      if (got_d[j] !== ref_data(arr[j])) $display("FAIL ovf_data[%0d]: got %h want %h", j, got_d[j], ref_data(arr[j]));
      else n_pass++;
      n_chk++;
      if (got_l[j] !== (j % 4 == 3)) $display("FAIL ovf_tlast[%0d]: got %b want %b", j, got_l[j], (j % 4 == 3));
      else n_pass++;
    end
    n_chk++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [IN_W-1:0]  arr [17];
    logic [OUT_W-1:0] got_d [32];
    int               k;
    do_reset();
    for (int i = 0; i < 17; i++) arr[i] = rand_sample();
    for (int i = 0; i < 16; i++) begin
      in_vld = 1'b1; in_data = arr[i];
      tick();
    end
    in_vld = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (ovf !== 1'b0) $display("FAIL fullrw_pre_ovf: got %b want 0", ovf); else n_pass++;
    in_vld = 1'b1; in_data = arr[16];
    tick();
    in_vld = 1'b0;
    tick();
    // the extra sample is in stage 2 and is written on the coming edge
    m_tready = 1'b1;
    n_chk++;
    if (m_tdata !== ref_data(arr[0])) $display("FAIL fullrw_head: got %h want %h", m_tdata, ref_data(arr[0]));
    else n_pass++;
    tick();
    m_tready = 1'b0;
    n_chk++; if (ovf !== 1'b0) $display("FAIL fullrw_ovf: got %b want 0", ovf); else n_pass++;
    tick();
    m_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (m_tvalid === 1'b1 && k < 32) begin got_d[k] = m_tdata; k++; end
      tick();
    end
    n_chk++; if (k != 16) $display("FAIL fullrw_count: got %0d want 16", k); else n_pass++;
    for (int j = 0; j < 16 && j < k; j++) begin
      n_chk++;
      if (got_d[j] !== ref_data(arr[j+1])) $display("FAIL fullrw_data[%0d]: got %h want %h", j, got_d[j], ref_data(arr[j+1]));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int   k;
    logic lasts [16];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_vld = 1'b1; in_data = rand_sample();
      tick();
    end
    in_vld = 1'b0;
    tick(); tick(); tick();
    m_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 11; c++) begin
      if (m_tvalid === 1'b1) k++;
      tick();
    end
    m_tready = 1'b0;
    n_chk++; if (k != 11) $display("FAIL rmid_partial_drain: got %0d want 11", k); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL rmid_pre_ovf: got %b want 1", ovf); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (m_tvalid !== 1'b0) $display("FAIL rmid_tvalid: got %b want 0", m_tvalid); else n_pass++;
    n_chk++; if (ovf !== 1'b0) $display("FAIL rmid_ovf: got %b want 0", ovf); else n_pass++;
    m_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_tvalid === 1'b1 && k < 16) begin lasts[k] = m_tlast; k++; end
      in_vld  = (c < 4);
      in_data = rand_sample();
      tick();
    end
    n_chk++; if (k != 4) $display("FAIL rmid_count: got %0d want 4", k); else n_pass++;
    for (int j = 0; j < 4 && j < k; j++) begin
      n_chk++;
      if (lasts[j] !== (j == 3)) $display("FAIL rmid_tlast[%0d]: got %b want %b", j, lasts[j], (j == 3));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      n_chk++;
      if (m_tvalid !== (exp_q.size() != 0)) $display("FAIL rand_tvalid@%0d: got %b want %b", c, m_tvalid, (exp_q.size() != 0));
      else n_pass++;
      if (exp_q.size() != 0) begin
        n_chk++;
        if (m_tdata !== exp_q[0][OUT_W-1:0]) $display("FAIL rand_tdata@%0d: got %h want %h", c, m_tdata, exp_q[0][OUT_W-1:0]);
        else n_pass++;
        n_chk++;
        if (m_tlast !== exp_q[0][OUT_W]) $display("FAIL rand_tlast@%0d: got %b want %b", c, m_tlast, exp_q[0][OUT_W]);
        else n_pass++;
      end
      n_chk++;
      if (clip !== exp_clip) $display("FAIL rand_clip@%0d: got %b want %b", c, clip, exp_clip);
      else n_pass++;
      n_chk++;
      if (ovf !== exp_ovf) $display("FAIL rand_ovf@%0d: got %b want %b", c, ovf, exp_ovf);
      else n_pass++;
      in_vld   = ($urandom_range(0, 99) < 75);
      in_data  = rand_sample();
      m_tready = (c < 800) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 40);
      tick();
    end
    in_vld = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; in_vld = 1'b0; in_data = '0; m_tready = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_frame();
    test_overflow();
    test_full_rw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
